mem_port_arbiter: RTL and testbench

Shares the single-ported 1024x32 data/instruction memory between two requesters: the fetch port (IF, read-only) and the load/store port (LS, read/write with byte enables) of the memory stage. It arbitrates requests using valid/ready handshakes and sequences each access to the synchronous SRAM, which has fixed read latency. It returns one response per accepted request and rejects out-of-range addresses with an error response.

---
 rtl/mem_port_arbiter.sv | 206 ++++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-ported synchronous SRAM (DEPTH x 32) between the fetch
//   port (IF, read-only) and the load/store port (LS, read/write with byte
//   enables). One request is serviced at a time: IDLE -> ACCESS -> [WAIT] -> RESP.
//   Out-of-range requests skip the SRAM and answer with err=1 the next cycle.
//   LS has priority, but after MAX_LS_BURST consecutive LS grants with IF
//   waiting, IF is granted once.
//
// Ports
//   clk, rst                 clock, asynchronous active-low reset
//   if_req_valid/ready/addr  fetch request handshake and byte address
//   if_rsp_valid/rdata/err   fetch response (one-cycle pulse, no backpressure)
//   ls_req_valid/ready/addr  load/store request handshake and byte address
//   ls_req_we/be/wdata       store flag, byte enables, store data
//   ls_rsp_valid/rdata/err   load/store response (also store ack)
//   mem_en/we/be/addr/wdata  SRAM command
//   mem_rdata                SRAM read data, valid MEM_LAT cycles after mem_en
module mem_port_arbiter #(
  parameter int unsigned DEPTH        = 1024,
  parameter int unsigned MEM_LAT      = 1,
  parameter int unsigned MAX_LS_BURST = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     if_req_valid,
  output logic                     if_req_ready,
  input  logic [31:0]              if_req_addr,
  output logic                     if_rsp_valid,
  output logic [31:0]              if_rsp_rdata,
  output logic                     if_rsp_err,
  input  logic                     ls_req_valid,
  output logic                     ls_req_ready,
  input  logic [31:0]              ls_req_addr,
  input  logic                     ls_req_we,
  input  logic [3:0]               ls_req_be,
  input  logic [31:0]              ls_req_wdata,
  output logic                     ls_rsp_valid,
  output logic [31:0]              ls_rsp_rdata,
  output logic                     ls_rsp_err,
  output logic                     mem_en,
  output logic                     mem_we,
  output logic [3:0]               mem_be,
  output logic [$clog2(DEPTH)-1:0] mem_addr,
  output logic [31:0]              mem_wdata,
  input  logic [31:0]              mem_rdata
);

  localparam int unsigned AW       = $clog2(DEPTH);
  localparam int unsigned BW       = $clog2(MAX_LS_BURST + 1);
  localparam int unsigned WW       = (MEM_LAT > 2) ? $clog2(MEM_LAT - 1) : 1;
  localparam int unsigned WaitLast = (MEM_LAT >= 2) ? MEM_LAT - 2 : 0;

  typedef enum logic [1:0] {StIdle, StAccess, StWait, StResp} state_e;

  state_e          state_q, state_d;
  logic [BW-1:0]   burst_q, burst_d;
  logic [WW-1:0]   wait_q, wait_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic            we_q, we_d;
  logic [3:0]      be_q, be_d;
  logic [31:0]     wdata_q, wdata_d;
  logic            owner_ls_q, owner_ls_d;
  logic            err_q, err_d;

  logic            grant_ls, grant_if;
  logic            hs_if, hs_ls;
  logic [31:0]     req_addr;
  logic            in_range;
  logic            resp_fire;
  logic [31:0]     rsp_data;
  logic [1:0]      unused_addr_lsbs;

  // LS wins ties unless it has already used up its burst allowance.
  always_comb begin
    grant_ls = ls_req_valid && !(if_req_valid && (burst_q == BW'(MAX_LS_BURST)));
    grant_if = if_req_valid && !grant_ls;
  end

  // Readies are forced low while reset is asserted so no output leaks out.
  assign if_req_ready = rst && (state_q == StIdle) && grant_if;
  assign ls_req_ready = rst && (state_q == StIdle) && grant_ls;

  assign hs_if = if_req_valid && if_req_ready;
  assign hs_ls = ls_req_valid && ls_req_ready;

  assign req_addr         = hs_ls ? ls_req_addr : if_req_addr;
  assign in_range         = ~|req_addr[31:AW+2];
  assign unused_addr_lsbs = req_addr[1:0];

  always_comb begin
    state_d    = state_q;
    burst_d    = burst_q;
    wait_d     = wait_q;
    addr_d     = addr_q;
    we_d       = we_q;
    be_d       = be_q;
    wdata_d    = wdata_q;
    owner_ls_d = owner_ls_q;
    err_d      = err_q;

    unique case (state_q)
      StIdle: begin
        if (hs_if || hs_ls) begin
          owner_ls_d = hs_ls;
          addr_d     = req_addr[AW+1:2];
          we_d       = hs_ls && ls_req_we;
          be_d       = hs_ls ? ls_req_be : 4'b0000;
          wdata_d    = hs_ls ? ls_req_wdata : 32'h0;
          err_d      = !in_range;
          state_d    = in_range ? StAccess : StResp;
        end
        if (hs_if) begin
          burst_d = '0;
        end else if (hs_ls) begin
          if (!if_req_valid) begin
            burst_d = '0;
          end else if (burst_q != BW'(MAX_LS_BURST)) begin
            burst_d = burst_q + BW'(1);
          end
        end
      end
      StAccess: begin
        wait_d  = '0;
        state_d = (MEM_LAT == 1) ? StResp : StWait;
      end
      StWait: begin
        if (wait_q == WW'(WaitLast)) begin
          state_d = StResp;
        end else begin
          wait_d = wait_q + WW'(1);
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      burst_q    <= '0;
      wait_q     <= '0;
      addr_q     <= '0;
      we_q       <= 1'b0;
      be_q       <= 4'b0000;
      wdata_q    <= 32'h0;
      owner_ls_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      burst_q    <= burst_d;
      wait_q     <= wait_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      be_q       <= be_d;
      wdata_q    <= wdata_d;
      owner_ls_q <= owner_ls_d;
      err_q      <= err_d;
    end
  end

  // SRAM command is driven only during ACCESS.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_be    = 4'b0000;
    mem_addr  = '0;
    mem_wdata = 32'h0;
    if (state_q == StAccess) begin
      mem_en    = 1'b1;
      mem_addr  = addr_q;
      mem_we    = we_q;
      mem_be    = we_q ? be_q : 4'b0000;
      mem_wdata = we_q ? wdata_q : 32'h0;
    end
  end

  // Load data passes straight through from the SRAM during RESP.
  assign resp_fire = (state_q == StResp);
  assign rsp_data  = (!we_q && !err_q) ? mem_rdata : 32'h0;

  always_comb begin
    if_rsp_valid = 1'b0;
    if_rsp_rdata = 32'h0;
    if_rsp_err   = 1'b0;
    ls_rsp_valid = 1'b0;
    ls_rsp_rdata = 32'h0;
    ls_rsp_err   = 1'b0;
    if (resp_fire) begin
      if (owner_ls_q) begin
        ls_rsp_valid = 1'b1;
        ls_rsp_rdata = rsp_data;
        ls_rsp_err   = err_q;
      end else begin
        if_rsp_valid = 1'b1;
        if_rsp_rdata = rsp_data;
        if_rsp_err   = err_q;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter. Instance "a" uses MEM_LAT=1, instance
// "b" uses MEM_LAT=2; each has its own behavioural SRAM.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  int n_checks = 0;
  int n_errors = 0;

  // Instance a (MEM_LAT=1)
  logic        a_if_req_valid, a_if_req_ready, a_if_rsp_valid, a_if_rsp_err;
  logic [31:0] a_if_req_addr, a_if_rsp_rdata;
  logic        a_ls_req_valid, a_ls_req_ready, a_ls_req_we, a_ls_rsp_valid, a_ls_rsp_err;
  logic [3:0]  a_ls_req_be, a_mem_be;
  logic [31:0] a_ls_req_addr, a_ls_req_wdata, a_ls_rsp_rdata;
  logic        a_mem_en, a_mem_we;
  logic [9:0]  a_mem_addr;
  logic [31:0] a_mem_wdata, a_mem_rdata;
  logic [31:0] mem_a [1024];

  // Instance b (MEM_LAT=2)
  logic        b_if_req_valid, b_if_req_ready, b_if_rsp_valid, b_if_rsp_err;
  logic [31:0] b_if_req_addr, b_if_rsp_rdata;
  logic        b_ls_req_valid, b_ls_req_ready, b_ls_req_we, b_ls_rsp_valid, b_ls_rsp_err;
  logic [3:0]  b_ls_req_be, b_mem_be;
  logic [31:0] b_ls_req_addr, b_ls_req_wdata, b_ls_rsp_rdata;
  logic        b_mem_en, b_mem_we;
  logic [9:0]  b_mem_addr;
  logic [31:0] b_mem_wdata, b_mem_rdata, b_rd1;
  logic [31:0] mem_b [1024];

  mem_port_arbiter #(.DEPTH(1024), .MEM_LAT(1), .MAX_LS_BURST(4)) dut_a (
    .clk(clk), .rst(rst),
    .if_req_valid(a_if_req_valid), .if_req_ready(a_if_req_ready), .if_req_addr(a_if_req_addr),
    .if_rsp_valid(a_if_rsp_valid), .if_rsp_rdata(a_if_rsp_rdata), .if_rsp_err(a_if_rsp_err),
    .ls_req_valid(a_ls_req_valid), .ls_req_ready(a_ls_req_ready), .ls_req_addr(a_ls_req_addr),
    .ls_req_we(a_ls_req_we), .ls_req_be(a_ls_req_be), .ls_req_wdata(a_ls_req_wdata),
    .ls_rsp_valid(a_ls_rsp_valid), .ls_rsp_rdata(a_ls_rsp_rdata), .ls_rsp_err(a_ls_rsp_err),
    .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_be(a_mem_be), .mem_addr(a_mem_addr),
    .mem_wdata(a_mem_wdata), .mem_rdata(a_mem_rdata)
  );

  mem_port_arbiter #(.DEPTH(1024), .MEM_LAT(2), .MAX_LS_BURST(4)) dut_b (
    .clk(clk), .rst(rst),
    .if_req_valid(b_if_req_valid), .if_req_ready(b_if_req_ready), .if_req_addr(b_if_req_addr),
    .if_rsp_valid(b_if_rsp_valid), .if_rsp_rdata(b_if_rsp_rdata), .if_rsp_err(b_if_rsp_err),
    .ls_req_valid(b_ls_req_valid), .ls_req_ready(b_ls_req_ready), .ls_req_addr(b_ls_req_addr),
    .ls_req_we(b_ls_req_we), .ls_req_be(b_ls_req_be), .ls_req_wdata(b_ls_req_wdata),
    .ls_rsp_valid(b_ls_rsp_valid), .ls_rsp_rdata(b_ls_rsp_rdata), .ls_rsp_err(b_ls_rsp_err),
    .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_be(b_mem_be), .mem_addr(b_mem_addr),
    .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata)
  );

  // SRAM models: contents preloaded while reset is low.
  always @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 1024; i++) mem_a[i] <= 32'hA5A5_0000 | i;
    end else if (a_mem_en) begin
      a_mem_rdata <= mem_a[a_mem_addr];
      if (a_mem_we)
        for (int i = 0; i < 4; i++)
          if (a_mem_be[i]) mem_a[a_mem_addr][8*i +: 8] <= a_mem_wdata[8*i +: 8];
    end
  end

  always @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 1024; i++) mem_b[i] <= (i == 2) ? 32'h1234_5678 : 32'h0;
    end else if (b_mem_en) begin
      b_rd1 <= mem_b[b_mem_addr];
      if (b_mem_we)
        for (int i = 0; i < 4; i++)
          if (b_mem_be[i]) mem_b[b_mem_addr][8*i +: 8] <= b_mem_wdata[8*i +: 8];
    end
    b_mem_rdata <= b_rd1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  int hs[$];
  int grants[$];
  int k;
  int seen;
  int if_ready_seen;

  initial begin
    rst = 1'b0;
    a_if_req_valid = 0; a_if_req_addr = 0;
    a_ls_req_valid = 0; a_ls_req_addr = 0; a_ls_req_we = 0; a_ls_req_be = 0; a_ls_req_wdata = 0;
    b_if_req_valid = 0; b_if_req_addr = 0;
    b_ls_req_valid = 0; b_ls_req_addr = 0; b_ls_req_we = 0; b_ls_req_be = 0; b_ls_req_wdata = 0;

    // Reset state, with valids asserted to show readies stay low.
    repeat (2) @(negedge clk);
    a_if_req_valid = 1; a_ls_req_valid = 1;
    #1;
    check("rst_if_ready", a_if_req_ready, 0);
    check("rst_ls_ready", a_ls_req_ready, 0);
    check("rst_mem_en", a_mem_en, 0);
    check("rst_rsp_valid", {a_if_rsp_valid, a_ls_rsp_valid}, 0);
    a_if_req_valid = 0; a_ls_req_valid = 0;
    @(negedge clk);
    rst = 1'b1;

    // Store then load on instance b (MEM_LAT=2).
    @(negedge clk);
    b_ls_req_valid = 1; b_ls_req_addr = 32'h8; b_ls_req_we = 1;
    b_ls_req_be = 4'b0011; b_ls_req_wdata = 32'hDEAD_BEEF;
    #1 check("st_ready", b_ls_req_ready, 1);
    @(negedge clk);
    b_ls_req_valid = 0;
    #1;
    check("st_mem_en", b_mem_en, 1);
    check("st_mem_we", b_mem_we, 1);
    check("st_mem_be", b_mem_be, 4'b0011);
    check("st_mem_addr", b_mem_addr, 2);
    check("st_mem_wdata", b_mem_wdata, 32'hDEAD_BEEF);
    @(negedge clk); #1;
    check("st_wait_mem_en", b_mem_en, 0);
    check("st_wait_rsp", b_ls_rsp_valid, 0);
    @(negedge clk); #1;
    check("st_ack_valid", b_ls_rsp_valid, 1);
    check("st_ack_rdata", b_ls_rsp_rdata, 0);
    check("st_ack_err", b_ls_rsp_err, 0);
    @(negedge clk);
    b_ls_req_valid = 1; b_ls_req_we = 0; b_ls_req_be = 0; b_ls_req_wdata = 0;
    #1 check("ld_ready", b_ls_req_ready, 1);
    @(negedge clk);
    b_ls_req_valid = 0;
    #1 check("ld_mem_we", {b_mem_en, b_mem_we}, 2'b10);
    @(negedge clk); #1;
    check("ld_wait_rsp", b_ls_rsp_valid, 0);
    @(negedge clk); #1;
    check("ld_rsp_valid", b_ls_rsp_valid, 1);
    check("ld_rsp_rdata", b_ls_rsp_rdata, 32'h1234_BEEF);

    // Single IF fetch on instance a.
    @(negedge clk);
    a_if_req_valid = 1; a_if_req_addr = 32'h40;
    #1;
    check("if_ready", a_if_req_ready, 1);
    check("if_ls_ready", a_ls_req_ready, 0);
    @(negedge clk);
    a_if_req_valid = 0;
    #1;
    check("if_mem_en", a_mem_en, 1);
    check("if_mem_addr", a_mem_addr, 16);
    check("if_mem_we", a_mem_we, 0);
    check("if_busy_ready", a_if_req_ready, 0);
    @(negedge clk); #1;
    check("if_rsp_valid", a_if_rsp_valid, 1);
    check("if_rsp_rdata", a_if_rsp_rdata, 32'hA5A5_0010);
    check("if_rsp_err", a_if_rsp_err, 0);
    check("if_ls_rsp_quiet", a_ls_rsp_valid, 0);
    @(negedge clk); #1;
    check("if_rsp_pulse", a_if_rsp_valid, 0);

    // Out-of-range LS load.
    @(negedge clk);
    a_ls_req_valid = 1; a_ls_req_addr = 32'h1000; a_ls_req_we = 0;
    #1 check("oor_ready", a_ls_req_ready, 1);
    @(negedge clk);
    a_ls_req_valid = 0;
    #1;
    check("oor_mem_en", a_mem_en, 0);
    check("oor_rsp_valid", a_ls_rsp_valid, 1);
    check("oor_rsp_err", a_ls_rsp_err, 1);
    check("oor_rsp_rdata", a_ls_rsp_rdata, 0);
    @(negedge clk);
    a_if_req_valid = 1; a_if_req_addr = 32'h0;
    #1;
    check("oor_idle_again", a_if_req_ready, 1);
    check("oor_mem_en_after", a_mem_en, 0);
    a_if_req_valid = 0;

    // Back-to-back IF throughput: handshakes 3 cycles apart.
    @(negedge clk);
    a_if_req_valid = 1; a_if_req_addr = 32'h40;
    k = 0;
    while (hs.size() < 3 && k < 20) begin
      #1;
      if (a_if_req_ready) hs.push_back(k);
      if (hs.size() < 3) begin
        @(negedge clk);
        k++;
      end
    end
    @(negedge clk);
    a_if_req_valid = 0;
    check("tp_count", hs.size(), 3);
    check("tp_gap1", (hs.size() == 3) ? hs[1] - hs[0] : -1, 3);
    check("tp_gap2", (hs.size() == 3) ? hs[2] - hs[1] : -1, 3);
    repeat (3) @(negedge clk);

    // Fairness with both valid.
    a_if_req_valid = 1; a_if_req_addr = 32'h0;
    a_ls_req_valid = 1; a_ls_req_addr = 32'h4; a_ls_req_we = 0;
    k = 0;
    while (grants.size() < 10 && k < 100) begin
      #1;
      if (a_ls_req_ready && a_if_req_ready) grants.push_back(2);
      else if (a_ls_req_ready) grants.push_back(1);
      else if (a_if_req_ready) grants.push_back(0);
      if (grants.size() < 10) begin
        @(negedge clk);
        k++;
      end
    end
    @(negedge clk);
    a_if_req_valid = 0; a_ls_req_valid = 0;
    check("fair_count", grants.size(), 10);
    for (int i = 0; i < 10; i++) begin
      check($sformatf("fair_grant%0d_is_ls", i), (i < grants.size()) ? grants[i] : 3,
            (i == 4 || i == 9) ? 0 : 1);
    end
    repeat (3) @(negedge clk);

    // LS alone: ten back-to-back grants, IF never granted.
    a_ls_req_valid = 1; a_ls_req_addr = 32'h4;
    seen = 0; if_ready_seen = 0; k = 0;
    while (seen < 10 && k < 100) begin
      #1;
      if (a_ls_req_ready) seen++;
      if (a_if_req_ready) if_ready_seen++;
      if (seen < 10) begin
        @(negedge clk);
        k++;
      end
    end
    @(negedge clk);
    a_ls_req_valid = 0;
    check("lsonly_grants", seen, 10);
    check("lsonly_no_if", if_ready_seen, 0);
    check("lsonly_last_cycle", k, 27);
    repeat (3) @(negedge clk);

    // Reset in the middle of an LS load's ACCESS cycle.
    a_ls_req_valid = 1; a_ls_req_addr = 32'h10; a_ls_req_we = 0;
    #1 check("rst_mid_ready", a_ls_req_ready, 1);
    @(negedge clk);
    #1 check("rst_mid_access", {a_mem_en, a_mem_addr}, {1'b1, 10'd4});
    rst = 1'b0;
    #1;
    check("rst_mid_mem_en", a_mem_en, 0);
    check("rst_mid_mem_addr", a_mem_addr, 0);
    check("rst_mid_mem_we_be", {a_mem_we, a_mem_be}, 0);
    check("rst_mid_mem_wdata", a_mem_wdata, 0);
    check("rst_mid_ls_ready", a_ls_req_ready, 0);
    check("rst_mid_rsp", {a_ls_rsp_valid, a_ls_rsp_err, a_if_rsp_valid, a_if_rsp_err}, 0);
    check("rst_mid_rdata", a_ls_rsp_rdata | a_if_rsp_rdata, 0);
    @(negedge clk);
    a_ls_req_valid = 0;
    rst = 1'b1;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); #1;
      if (a_ls_rsp_valid) seen++;
    end
    check("rst_mid_no_rsp", seen, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no completion, required completion");
    $fatal(1, "bench timeout");
  end

endmodule
